// File: rtl/word_packer_pkg.sv
// Shared sizing helpers and reset values for the word packer and its FIFO.
package word_packer_pkg;

  // Packed word width.
  function automatic int unsigned pw(input int unsigned width, input int unsigned nwords);
    return width * nwords;
  endfunction

  // Width of a 0..DEPTH inclusive occupancy count.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned CNT_RST      = 0;
  localparam logic        OVERFLOW_RST = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted only with a read on the same edge.
module sync_fifo
  import word_packer_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [lvl_w(DEPTH)-1:0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          wr_ok, rd_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign level   = level_q;
  assign rd_data = empty ? '0 : mem[rptr_q];

  // Storage array; no reset needed since empty masks the read port.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wr_data;
  end

  // Occupancy next-state.
  always_comb begin
    level_d = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/word_packer.sv
// Packs NWORDS enable-qualified WIDTH-bit words (first word in the MSBs) into one packed word,
// buffers them in a show-ahead FIFO and presents them on a valid/ready interface.
// Optional build macro WORD_PACKER_PARITY_EN adds a stored even-parity bit and out_parity.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NWORDS = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_en,
  input  logic                          flush,
  output logic [pw(WIDTH, NWORDS)-1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [lvl_w(DEPTH)-1:0]       level,
  output logic                          overflow
`ifdef WORD_PACKER_PARITY_EN
  ,
  output logic                          out_parity
`endif
);

  localparam int unsigned PW = pw(WIDTH, NWORDS);
  localparam int unsigned CW = $clog2(NWORDS);
`ifdef WORD_PACKER_PARITY_EN
  localparam int unsigned DW = PW + 1;
`else
  localparam int unsigned DW = PW;
`endif

  logic [PW-1:0] acc_q, acc_d, acc_shift, push_data;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, full, empty, overflow_q;
  logic [DW-1:0] fifo_wdata, fifo_rdata;
  int unsigned   pad_sh;

  assign acc_shift = {acc_q[PW-WIDTH-1:0], in_data};
  assign pop       = out_ready && !empty;

  // Accumulate words; close the packed word on the last slot or on flush (zero-padded).
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = '0;
    pad_sh    = 0;
    if (in_en) begin
      if (cnt_q == CW'(NWORDS - 1)) begin
        push      = 1'b1;
        push_data = acc_shift;
        acc_d     = '0;
        cnt_d     = '0;
      end else if (flush) begin
        // in_data joins first, then the remaining empty slots are padded.
        push      = 1'b1;
        pad_sh    = (NWORDS - 1 - 32'(cnt_q)) * WIDTH;
        push_data = acc_shift << pad_sh;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (flush && (cnt_q != '0)) begin
      push      = 1'b1;
      pad_sh    = (NWORDS - 32'(cnt_q)) * WIDTH;
      push_data = acc_q << pad_sh;
      acc_d     = '0;
      cnt_d     = '0;
    end
  end

  // Packer state and sticky overflow; a push into a full FIFO without a pop is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= CW'(CNT_RST);
      overflow_q <= OVERFLOW_RST;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

`ifdef WORD_PACKER_PARITY_EN
  assign fifo_wdata = {^push_data, push_data};
  assign out_parity = fifo_rdata[PW];
`else
  assign fifo_wdata = push_data;
`endif

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign out_data  = fifo_rdata[PW-1:0];
  assign out_valid = !empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer (WIDTH=4, NWORDS=4, DEPTH=4).
module tb_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_data;
  logic        in_en;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
`ifdef WORD_PACKER_PARITY_EN
  logic        out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  word_packer #(
    .WIDTH  (4),
    .NWORDS (4),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_en     (in_en),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
`ifdef WORD_PACKER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d);
    in_en   = 1'b1;
    in_data = d;
    tick();
    in_en   = 1'b0;
    in_data = '0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*4 +: 4]);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_en     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Basic packing, one-cycle latency, single-cycle valid with ready high.
    out_ready = 1'b1;
    send(4'h1);
    send(4'h2);
    send(4'h3);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    send(4'h4);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h1234);
    chk("t1_level", 32'(level), 32'd1);
    tick();
    chk("t1_valid_one_cycle", 32'(out_valid), 32'd0);
    chk("t1_data_empty", 32'(out_data), 32'd0);

    // Flush alone after two words pads low slots; next word proves cnt cleared.
    send(4'hA);
    send(4'hB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_flush_data", 32'(out_data), 32'hAB00);
    chk("t2_flush_level", 32'(level), 32'd1);
    send_word(16'h1234);
    chk("t2_after_flush", 32'(out_data), 32'h1234);
    chk("t2_after_level", 32'(level), 32'd1);
    tick();
    chk("t2_drained", 32'(out_valid), 32'd0);

    // Flush with cnt == 0 is a no-op.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_empty_flush_valid", 32'(out_valid), 32'd0);
    chk("t2_empty_flush_level", 32'(level), 32'd0);

    // Flush together with in_en: in_data joins first, exactly one push.
    send(4'hA);
    send(4'hB);
    flush = 1'b1;
    send(4'hC);
    flush = 1'b0;
    chk("t2_flush_en_data", 32'(out_data), 32'hABC0);
    chk("t2_flush_en_level", 32'(level), 32'd1);
    tick();
    chk("t2_flush_en_single", 32'(level), 32'd0);

    // Flush on the completing word is an ordinary push.
    send(4'h1);
    send(4'h2);
    send(4'h3);
    flush = 1'b1;
    send(4'h4);
    flush = 1'b0;
    chk("t2_flush_full_data", 32'(out_data), 32'h1234);
    tick();
    chk("t2_flush_full_single", 32'(level), 32'd0);

    // Overflow: fill with ready low, fifth word dropped.
    out_ready = 1'b0;
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h4444);
    chk("t3_full_level", 32'(level), 32'd4);
    chk("t3_no_overflow_yet", 32'(overflow), 32'd0);
    send_word(16'h5555);
    chk("t3_level_after_drop", 32'(level), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    chk("t3_pop0", 32'(out_data), 32'h1111);
    tick();
    chk("t3_pop1", 32'(out_data), 32'h2222);
    tick();
    chk("t3_pop2", 32'(out_data), 32'h3333);
    tick();
    chk("t3_pop3", 32'(out_data), 32'h4444);
    tick();
    chk("t3_empty_valid", 32'(out_valid), 32'd0);
    chk("t3_empty_level", 32'(level), 32'd0);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Reset clears overflow; push into full FIFO with simultaneous pop is accepted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);
    out_ready = 1'b0;
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h4444);
    send(4'h5);
    send(4'h5);
    send(4'h5);
    out_ready = 1'b1;
    send(4'h5);
    chk("t4_level_kept", 32'(level), 32'd4);
    chk("t4_no_overflow", 32'(overflow), 32'd0);
    chk("t4_head", 32'(out_data), 32'h2222);
    tick();
    chk("t4_pop1", 32'(out_data), 32'h3333);
    tick();
    chk("t4_pop2", 32'(out_data), 32'h4444);
    tick();
    chk("t4_fifth_last", 32'(out_data), 32'h5555);
    tick();
    chk("t4_drained", 32'(out_valid), 32'd0);

    // Reset mid-word discards the partial word.
    send(4'h9);
    send(4'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(4'h5);
    send(4'h6);
    send(4'h7);
    chk("t5_no_stale_push", 32'(out_valid), 32'd0);
    send(4'h8);
    chk("t5_data", 32'(out_data), 32'h5678);
    chk("t5_level", 32'(level), 32'd1);
    tick();
    chk("t5_level_zero", 32'(level), 32'd0);
    chk("t5_valid_zero", 32'(out_valid), 32'd0);

`ifdef WORD_PACKER_PARITY_EN
    // Parity of the head entry; zero when empty.
    out_ready = 1'b0;
    send_word(16'h1234);
    chk("par_1234", 32'(out_parity), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("par_empty", 32'(out_parity), 32'd0);
    out_ready = 1'b0;
    send(4'h3);
    send(4'h3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("par_3300_data", 32'(out_data), 32'h3300);
    chk("par_3300", 32'(out_parity), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
